id_exe_stage_reg: RTL and testbench
===================================

# id_exe_stage_reg

Pipeline register between the decode stage (control unit, register file, condition check) and the execute stage of the ARM-subset pipeline. Captures the 9-bit decoded control word plus operands, PC, immediate fields and destination on each rising clock edge. Supports hazard freeze, branch flush and condition-fail squashing, and provides a valid bit to the execute stage and hazard logic.

## Interface
- DATA_W, 32, width of PC and operand values

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- freeze  in  1  hazard stall: hold all outputs
- flush  in  1  branch taken in EXE: squash this stage
- ctrl_in  in  9  {alu_cmd[3:0], mem_read, mem_write, reg_write, branch, s_bit} from control unit
- cond_pass  in  1  condition-check result for the decoded instruction
- valid_in  in  1  decode stage holds a real instruction
- pc_in  in  DATA_W  PC+4 of the instruction
- val_rn_in, val_rm_in  in  DATA_W  register-file read values
- imm_in  in  1  I bit
- shift_operand_in  in  12  shifter operand field
- simm24_in  in  24  branch offset
- dest_in  in  4  destination register
- status_in  in  4  current NZCV
- alu_cmd_out  out  4; mem_read_out, mem_write_out, reg_write_out, branch_out, s_out  out  1 each
- valid_out  out  1  stage holds a live instruction
- pc_out, val_rn_out, val_rm_out  out  DATA_W
- imm_out  out  1; shift_operand_out  out  12; simm24_out  out  24; dest_out  out  4; status_out  out  4

## Operation
- Reset (rst_n=0, asynchronous): every output is 0, including valid_out and alu_cmd_out.
- Per rising edge, priority: flush > freeze > load.
- flush=1: valid_out, mem_read_out, mem_write_out, reg_write_out, branch_out, s_out <= 0; alu_cmd_out <= 0; data fields (pc, vals, imm, shift, simm24, dest, status) hold.
- flush=0, freeze=1: all outputs hold their value.
- Load: all data fields <= inputs. Kill = ~valid_in | ~cond_pass.
  - Kill=0: control fields <= ctrl_in slices; valid_out <= 1.
  - Kill=1: mem_read, mem_write, reg_write, branch, s <= 0; alu_cmd <= ctrl_in alu_cmd; valid_out <= valid_in.
- Side-effecting bits (reg_write, mem_read, mem_write, branch, s) are therefore never 1 while valid_out=0.
- No arithmetic; values pass unmodified, no width conversion.

## Timing
- Latency: 1 cycle input-to-output; outputs are pure flops, no combinational input-to-output paths.
- freeze asserted for N cycles holds outputs for exactly N edges; load resumes on the first edge with freeze=0.
- flush and freeze together: flush wins; the frozen instruction is discarded.
- Reset asserted mid-freeze or mid-flush clears outputs immediately (asynchronously); first load occurs on the first rising edge after rst_n rises.

## Configuration
- FORWARDING_EN defined: adds inputs src1_in[3:0], src2_in[3:0] and outputs src1_out[3:0], src2_out[3:0]; these load and hold like the data fields, reset to 0 and are unaffected by flush. They feed the forwarding unit.
- FORWARDING_EN undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Reset: drive nonzero inputs, pulse rst_n low between edges -> all outputs 0 without a clock edge.
- ADD load: ctrl_in=9'b0010_0_0_1_0_1, cond_pass=1, valid_in=1, val_rn_in=32'h5, dest_in=4'd3 -> next edge alu_cmd_out=4'b0010, reg_write_out=1, s_out=1, valid_out=1, val_rn_out=5, dest_out=3.
- Condition fail: same instruction with cond_pass=0 -> reg_write_out=0, s_out=0, valid_out=1, alu_cmd_out=4'b0010.
- Freeze: load LDR (ctrl_in=9'b0010_1_0_1_0_1), then hold freeze=1 for 3 edges while changing inputs -> outputs unchanged for 3 edges, new values on edge 4.
- Flush over freeze: flush=1, freeze=1 with STR loaded -> mem_write_out=0, valid_out=0, alu_cmd_out=0, pc_out unchanged.
- FORWARDING_EN build: src1_in=4'd7, src2_in=4'd9 load -> src1_out=7, src2_out=9; subsequent flush leaves them 7/9.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: control word, operands and immediates with freeze, flush and kill handling.
// Optional FORWARDING_EN macro adds src1/src2 register-number passthrough for the forwarding unit.
module id_exe_stage_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic [8:0]        ctrl_in,
  input  logic              cond_pass,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       simm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        status_in,
`ifdef FORWARDING_EN
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
`endif
  output logic [3:0]        alu_cmd_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              reg_write_out,
  output logic              branch_out,
  output logic              s_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       simm24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        status_out
);

  logic [3:0]        alu_cmd_q, alu_cmd_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              reg_write_q, reg_write_d;
  logic              branch_q, branch_d;
  logic              s_q, s_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] val_rn_q, val_rn_d;
  logic [DATA_W-1:0] val_rm_q, val_rm_d;
  logic              imm_q, imm_d;
  logic [11:0]       shift_q, shift_d;
  logic [23:0]       simm24_q, simm24_d;
  logic [3:0]        dest_q, dest_d;
  logic [3:0]        status_q, status_d;
`ifdef FORWARDING_EN
  logic [3:0]        src1_q, src1_d;
  logic [3:0]        src2_q, src2_d;
`endif

  logic kill;
  assign kill = ~valid_in | ~cond_pass;

  always_comb begin
    alu_cmd_d   = alu_cmd_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    branch_d    = branch_q;
    s_d         = s_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    val_rn_d    = val_rn_q;
    val_rm_d    = val_rm_q;
    imm_d       = imm_q;
    shift_d     = shift_q;
    simm24_d    = simm24_q;
    dest_d      = dest_q;
    status_d    = status_q;
`ifdef FORWARDING_EN
    src1_d      = src1_q;
    src2_d      = src2_q;
`endif
    if (flush) begin
      // Only control/valid are squashed; data fields are left untouched.
      alu_cmd_d   = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
      branch_d    = 1'b0;
      s_d         = 1'b0;
      valid_d     = 1'b0;
    end else if (!freeze) begin
      pc_d     = pc_in;
      val_rn_d = val_rn_in;
      val_rm_d = val_rm_in;
      imm_d    = imm_in;
      shift_d  = shift_operand_in;
      simm24_d = simm24_in;
      dest_d   = dest_in;
      status_d = status_in;
`ifdef FORWARDING_EN
      src1_d   = src1_in;
      src2_d   = src2_in;
`endif
      alu_cmd_d = ctrl_in[8:5];
      if (kill) begin
        // A condition-failed instruction stays valid but loses every side effect.
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        branch_d    = 1'b0;
        s_d         = 1'b0;
        valid_d     = valid_in;
      end else begin
        mem_read_d  = ctrl_in[4];
        mem_write_d = ctrl_in[3];
        reg_write_d = ctrl_in[2];
        branch_d    = ctrl_in[1];
        s_d         = ctrl_in[0];
        valid_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cmd_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      branch_q    <= 1'b0;
      s_q         <= 1'b0;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      val_rn_q    <= '0;
      val_rm_q    <= '0;
      imm_q       <= 1'b0;
      shift_q     <= '0;
      simm24_q    <= '0;
      dest_q      <= '0;
      status_q    <= '0;
`ifdef FORWARDING_EN
      src1_q      <= '0;
      src2_q      <= '0;
`endif
    end else begin
      alu_cmd_q   <= alu_cmd_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      branch_q    <= branch_d;
      s_q         <= s_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      val_rn_q    <= val_rn_d;
      val_rm_q    <= val_rm_d;
      imm_q       <= imm_d;
      shift_q     <= shift_d;
      simm24_q    <= simm24_d;
      dest_q      <= dest_d;
      status_q    <= status_d;
`ifdef FORWARDING_EN
      src1_q      <= src1_d;
      src2_q      <= src2_d;
`endif
    end
  end

  assign alu_cmd_out       = alu_cmd_q;
  assign mem_read_out      = mem_read_q;
  assign mem_write_out     = mem_write_q;
  assign reg_write_out     = reg_write_q;
  assign branch_out        = branch_q;
  assign s_out             = s_q;
  assign valid_out         = valid_q;
  assign pc_out            = pc_q;
  assign val_rn_out        = val_rn_q;
  assign val_rm_out        = val_rm_q;
  assign imm_out           = imm_q;
  assign shift_operand_out = shift_q;
  assign simm24_out        = simm24_q;
  assign dest_out          = dest_q;
  assign status_out        = status_q;
`ifdef FORWARDING_EN
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg: reset, load, kill, freeze, flush and async reset cases.
module tb_id_exe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush;
  logic [8:0]  ctrl_in;
  logic        cond_pass, valid_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] simm24_in;
  logic [3:0]  dest_in, status_in;
  logic [3:0]  alu_cmd_out;
  logic        mem_read_out, mem_write_out, reg_write_out, branch_out, s_out, valid_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] simm24_out;
  logic [3:0]  dest_out, status_out;
`ifdef FORWARDING_EN
  logic [3:0]  src1_in, src2_in, src1_out, src2_out;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .ctrl_in(ctrl_in), .cond_pass(cond_pass), .valid_in(valid_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in), .simm24_in(simm24_in),
    .dest_in(dest_in), .status_in(status_in),
`ifdef FORWARDING_EN
    .src1_in(src1_in), .src2_in(src2_in), .src1_out(src1_out), .src2_out(src2_out),
`endif
    .alu_cmd_out(alu_cmd_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .reg_write_out(reg_write_out), .branch_out(branch_out), .s_out(s_out),
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .imm_out(imm_out), .shift_operand_out(shift_operand_out), .simm24_out(simm24_out),
    .dest_out(dest_out), .status_out(status_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [3:0] alu, input logic mr, input logic mw,
                            input logic rw, input logic br, input logic s, input logic v);
    check({tag, ".alu"}, {28'd0, alu_cmd_out}, {28'd0, alu});
    check({tag, ".ctl"}, {26'd0, mem_read_out, mem_write_out, reg_write_out, branch_out, s_out, valid_out},
          {26'd0, mr, mw, rw, br, s, v});
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;
    ctrl_in = 9'h1FF; cond_pass = 1'b1; valid_in = 1'b1;
    pc_in = 32'hDEADBEEF; val_rn_in = 32'h11111111; val_rm_in = 32'h22222222;
    imm_in = 1'b1; shift_operand_in = 12'hABC; simm24_in = 24'h123456;
    dest_in = 4'hF; status_in = 4'hA;
`ifdef FORWARDING_EN
    src1_in = 4'd1; src2_in = 4'd2;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_ctrl("reset_held", 4'h0, 0, 0, 0, 0, 0, 0);
    check("reset_held.pc", pc_out, 32'h0);
    check("reset_held.simm", {8'd0, simm24_out}, 32'h0);

    rst_n = 1'b1;
    tick;
    check_ctrl("load_all1", 4'hF, 1, 1, 1, 1, 1, 1);
    check("load_all1.pc", pc_out, 32'hDEADBEEF);
    check("load_all1.shift", {20'd0, shift_operand_out}, 32'hABC);

    // async reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_ctrl("async_rst", 4'h0, 0, 0, 0, 0, 0, 0);
    check("async_rst.pc", pc_out, 32'h0);
    check("async_rst.rn", val_rn_out, 32'h0);
    check("async_rst.misc", {imm_out, dest_out, status_out}, 9'h0);
    rst_n = 1'b1;

    // ADD with S
    ctrl_in = 9'b0010_0_0_1_0_1; val_rn_in = 32'h5; val_rm_in = 32'h7; dest_in = 4'd3;
    pc_in = 32'h4; imm_in = 1'b0; status_in = 4'h0;
    tick;
    check_ctrl("add", 4'b0010, 0, 0, 1, 0, 1, 1);
    check("add.rn", val_rn_out, 32'h5);
    check("add.dest", {28'd0, dest_out}, 32'd3);

    // condition fail
    cond_pass = 1'b0; pc_in = 32'h8;
    tick;
    check_ctrl("condfail", 4'b0010, 0, 0, 0, 0, 0, 1);
    check("condfail.pc", pc_out, 32'h8);

    // bubble from decode
    cond_pass = 1'b1; valid_in = 1'b0; ctrl_in = 9'b1101_1_1_1_1_1; pc_in = 32'hC;
    tick;
    check_ctrl("bubble", 4'b1101, 0, 0, 0, 0, 0, 0);

    // LDR then freeze for 3 edges
    valid_in = 1'b1; ctrl_in = 9'b0010_1_0_1_0_1; pc_in = 32'h100; val_rn_in = 32'h40; dest_in = 4'd5;
    tick;
    check_ctrl("ldr", 4'b0010, 1, 0, 1, 0, 1, 1);
    check("ldr.pc", pc_out, 32'h100);
    freeze = 1'b1;
    ctrl_in = 9'b0100_0_1_0_0_0; pc_in = 32'h104; val_rn_in = 32'h99; dest_in = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_ctrl("frz", 4'b0010, 1, 0, 1, 0, 1, 1);
      check("frz.pc", pc_out, 32'h100);
      check("frz.rn", val_rn_out, 32'h40);
    end
    freeze = 1'b0;
    tick;
    check_ctrl("frz_release", 4'b0100, 0, 1, 0, 0, 0, 1);
    check("frz_release.pc", pc_out, 32'h104);
    check("frz_release.dest", {28'd0, dest_out}, 32'd9);

    // flush wins over freeze; data fields hold
`ifdef FORWARDING_EN
    src1_in = 4'd7; src2_in = 4'd9;
    tick;
    check("fwd.src", {24'd0, src1_out, src2_out}, 32'h79);
`endif
    flush = 1'b1; freeze = 1'b1; pc_in = 32'h300; val_rn_in = 32'h77;
`ifdef FORWARDING_EN
    src1_in = 4'd2; src2_in = 4'd3;
`endif
    tick;
    check_ctrl("flush_frz", 4'h0, 0, 0, 0, 0, 0, 0);
    check("flush_frz.pc", pc_out, 32'h104);
    check("flush_frz.rn", val_rn_out, 32'h99);
`ifdef FORWARDING_EN
    check("flush.src", {24'd0, src1_out, src2_out}, 32'h79);
`endif

    // flush alone also holds data
    freeze = 1'b0;
    tick;
    check_ctrl("flush", 4'h0, 0, 0, 0, 0, 0, 0);
    check("flush.pc", pc_out, 32'h104);

    // branch load
    flush = 1'b0; ctrl_in = 9'b0000_0_0_0_1_0; simm24_in = 24'hFFFFFE; pc_in = 32'h400;
    tick;
    check_ctrl("branch", 4'h0, 0, 0, 0, 1, 0, 1);
    check("branch.simm", {8'd0, simm24_out}, 32'h00FFFFFE);
    check("branch.pc", pc_out, 32'h400);

    // reset mid-freeze, first load on first edge after release
    freeze = 1'b1;
    tick;
    rst_n = 1'b0;
    #1;
    check_ctrl("rst_frz", 4'h0, 0, 0, 0, 0, 0, 0);
    check("rst_frz.pc", pc_out, 32'h0);
    rst_n = 1'b1; freeze = 1'b0;
    tick;
    check_ctrl("post_rst", 4'h0, 0, 0, 0, 1, 0, 1);
    check("post_rst.pc", pc_out, 32'h400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
